// File: rtl/sram_controller.sv
// Purpose: single-word bus slave driving one asynchronous 32-bit SRAM with programmable wait states.
// Latency: read completes at T+WAIT_CYCLES+2, write at T+WAIT_CYCLES+4, zero-mask write (and cached read hit) at T+1.
// Backpressure: stall stays high while a request is held and not in its DONE cycle; optional macro SRAM_READ_CACHE_EN adds a one-entry read buffer.
module sram_controller #(
  parameter int WAIT_CYCLES     = 1,
  parameter int CHIP_ADDR_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                address,
  input  logic                       read,
  input  logic                       write,
  input  logic [31:0]                data_wr,
  input  logic [3:0]                 mask,
  output logic                       stall,
  output logic [31:0]                data_rd,
  output logic [31:0]                data_rd_2,
  output logic [5:0]                 interrupt,
  output logic [CHIP_ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [31:0]                sram_data,
  output logic [3:0]                 sram_be_n,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

  // Last value of the wait counter in RD and WR_PULSE; the strobe phase lasts CNT_LAST+1 cycles.
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

  state_t                     state;
  logic [3:0]                 cnt;
  logic [31:0]                wdata_q;
  logic                       drive_en;
  logic [CHIP_ADDR_WIDTH-1:0] req_addr;
  logic                       unused_addr_bits;

  assign req_addr         = address[CHIP_ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{address[31:CHIP_ADDR_WIDTH+2], address[1:0]};

  // The data bus is only driven while the write strobe window is open; the enable is registered.
  assign sram_data = drive_en ? wdata_q : 32'bz;

  // A held request sees stall drop exactly in DONE, so the master releases it before IDLE resamples.
  assign stall     = !rst && (read || write) && (state != DONE);
  assign data_rd_2 = '0;
  assign interrupt = '0;

`ifdef SRAM_READ_CACHE_EN
  logic                       c_valid;
  logic [CHIP_ADDR_WIDTH-1:0] c_tag;
  logic [31:0]                c_data;
  logic                       c_hit;

  assign c_hit = c_valid && (c_tag == req_addr);
`endif

  // Access sequencer: all chip strobes, address and read data are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= 4'hF;
      sram_addr <= '0;
      drive_en  <= 1'b0;
      wdata_q   <= '0;
      data_rd   <= '0;
`ifdef SRAM_READ_CACHE_EN
      c_valid   <= 1'b0;
      c_tag     <= '0;
      c_data    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (write) begin
            // Write beats read when both are requested; an empty mask touches nothing.
            if (mask != 4'h0) begin
              state     <= WR_SETUP;
              sram_addr <= req_addr;
              wdata_q   <= data_wr;
              sram_be_n <= ~mask;
              sram_ce_n <= 1'b0;
              drive_en  <= 1'b1;
            end else begin
              state <= DONE;
            end
          end else if (read) begin
`ifdef SRAM_READ_CACHE_EN
            if (c_hit) begin
              state   <= DONE;
              data_rd <= c_data;
            end else
`endif
            begin
              state     <= RD;
              sram_addr <= req_addr;
              sram_ce_n <= 1'b0;
              sram_oe_n <= 1'b0;
              sram_be_n <= 4'h0;
            end
          end
        end
        RD: begin
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            cnt       <= '0;
            data_rd   <= sram_data;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= 4'hF;
`ifdef SRAM_READ_CACHE_EN
            c_valid   <= 1'b1;
            c_tag     <= sram_addr;
            c_data    <= sram_data;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_SETUP: begin
          state     <= WR_PULSE;
          cnt       <= '0;
          sram_we_n <= 1'b0;
        end
        WR_PULSE: begin
          if (cnt == CNT_LAST) begin
            state     <= WR_HOLD;
            cnt       <= '0;
            sram_we_n <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_HOLD: begin
          state     <= DONE;
          cnt       <= '0;
          sram_ce_n <= 1'b1;
          sram_be_n <= 4'hF;
          drive_en  <= 1'b0;
`ifdef SRAM_READ_CACHE_EN
          // Keep the buffered word coherent with the bytes just written to the same chip word.
          if (c_valid && (c_tag == sram_addr)) begin
            for (int i = 0; i < 4; i++) begin
              if (!sram_be_n[i]) c_data[8*i +: 8] <= wdata_q[8*i +: 8];
            end
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Purpose: directed bench for sram_controller with an SRAM chip model and a cycle-level expectation model.
// Latency: expectations follow the completion-time rules T+W+2 (read), T+W+4 (write), T+1 (empty mask / buffer hit).
// Backpressure: the bench holds each request until its completion cycle, then drops it for one idle cycle.
module tb_sram_controller;

  localparam int          W     = 1;
  localparam logic [31:0] PROBE = 32'hA5C3_3C5A;
`ifdef SRAM_READ_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] data_wr;
  logic [3:0]  mask;
  logic        stall;
  logic [31:0] data_rd;
  logic [31:0] data_rd_2;
  logic [5:0]  interrupt;
  logic [19:0] sram_addr;
  wire  [31:0] sram_data;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(W), .CHIP_ADDR_WIDTH(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .read      (read),
    .write     (write),
    .data_wr   (data_wr),
    .mask      (mask),
    .stall     (stall),
    .data_rd   (data_rd),
    .data_rd_2 (data_rd_2),
    .interrupt (interrupt),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_be_n (sram_be_n),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  // Chip model: drives stored data on an output-enabled read, a probe pattern while deselected.
  logic [31:0] chip_mem [256];
  logic [31:0] ref_mem  [256];
  logic        chk_en = 1'b0;

  assign sram_data = (sram_ce_n || !sram_oe_n) ?
                     (sram_ce_n ? PROBE : chip_mem[sram_addr[7:0]]) : 32'bz;

  // Chip write: bytes enabled by be_n are stored on every clock with ce_n and we_n low.
  always @(posedge clk) begin
    if (chk_en && !sram_ce_n && !sram_we_n) begin
      for (int i = 0; i < 4; i++) begin
        if (!sram_be_n[i]) chip_mem[sram_addr[7:0]][8*i +: 8] <= sram_data[8*i +: 8];
      end
    end
  end

  // Expected pin values for the current cycle, set by the stimulus from the timing rules.
  logic        exp_stall, exp_ce, exp_oe, exp_we, exp_drive;
  logic [3:0]  exp_be;
  logic [19:0] exp_addr;
  logic [31:0] exp_wdata, exp_rd;

  // Read-buffer model (only consulted when the buffer is built in).
  logic        m_valid = 1'b0;
  logic [19:0] m_tag   = '0;
  logic [31:0] m_data  = '0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("ce_n", 32'(sram_ce_n), 32'(exp_ce));
      chk("oe_n", 32'(sram_oe_n), 32'(exp_oe));
      chk("we_n", 32'(sram_we_n), 32'(exp_we));
      chk("be_n", 32'(sram_be_n), 32'(exp_be));
      chk("data_rd", data_rd, exp_rd);
      chk("data_rd_2", data_rd_2, 32'h0);
      chk("interrupt", 32'(interrupt), 32'h0);
      chk("oe_we_excl", 32'(!sram_oe_n && !sram_we_n), 32'h0);
      if (!exp_ce) chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
      if (exp_drive) chk("bus_wdata", sram_data, exp_wdata);
      else if (exp_ce) chk("bus_release", sram_data, PROBE);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_stall = 1'b0;
    exp_ce    = 1'b1;
    exp_oe    = 1'b1;
    exp_we    = 1'b1;
    exp_be    = 4'hF;
    exp_drive = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic also_read);
    int  last;
    logic [7:0] idx;
    idx     = a[9:2];
    last    = (m == 4'h0) ? 1 : W + 4;
    address = a;
    data_wr = d;
    mask    = m;
    write   = 1'b1;
    read    = also_read;
    for (int k = 0; k <= last; k++) begin
      exp_stall = (k != last);
      exp_ce    = !(m != 4'h0 && k >= 1 && k <= W + 3);
      exp_we    = !(m != 4'h0 && k >= 2 && k <= W + 2);
      exp_oe    = 1'b1;
      exp_be    = (m != 4'h0 && k >= 1 && k <= W + 3) ? ~m : 4'hF;
      exp_drive = (m != 4'h0 && k >= 1 && k <= W + 3);
      exp_wdata = d;
      exp_addr  = a[21:2];
      step();
    end
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        ref_mem[idx][8*i +: 8] = d[8*i +: 8];
        if (m_valid && m_tag == a[21:2]) m_data[8*i +: 8] = d[8*i +: 8];
      end
    end
    write = 1'b0;
    read  = 1'b0;
    set_idle();
    step();
  endtask

  task automatic do_read(input logic [31:0] a);
    int   last;
    logic hit;
    logic active;
    logic [7:0] idx;
    idx     = a[9:2];
    hit     = CACHE && m_valid && (m_tag == a[21:2]);
    last    = hit ? 1 : W + 2;
    address = a;
    read    = 1'b1;
    write   = 1'b0;
    mask    = 4'h0;
    for (int k = 0; k <= last; k++) begin
      active    = !hit && k >= 1 && k <= W + 1;
      exp_stall = (k != last);
      exp_ce    = !active;
      exp_oe    = !active;
      exp_we    = 1'b1;
      exp_be    = active ? 4'h0 : 4'hF;
      exp_drive = 1'b0;
      exp_addr  = a[21:2];
      if (k == last) exp_rd = hit ? m_data : ref_mem[idx];
      step();
    end
    m_valid = 1'b1;
    m_tag   = a[21:2];
    m_data  = exp_rd;
    read    = 1'b0;
    set_idle();
    step();
  endtask

  // Reset lands in the first WR_PULSE cycle of a write and is held one more cycle.
  task automatic write_with_reset(input logic [31:0] a, input logic [31:0] d);
    address = a;
    data_wr = d;
    mask    = 4'hF;
    write   = 1'b1;
    read    = 1'b0;
    set_idle();
    exp_stall = 1'b1;
    step();
    exp_ce = 1'b0; exp_be = 4'h0; exp_drive = 1'b1; exp_wdata = d; exp_addr = a[21:2];
    step();
    rst = 1'b1;
    exp_stall = 1'b0;
    exp_we    = 1'b0;
    step();
    set_idle();
    exp_rd  = 32'h0;
    m_valid = 1'b0;
    step();
    rst   = 1'b0;
    write = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      chip_mem[i] = 32'h5A00_0000 | 32'(i);
      ref_mem[i]  = 32'h5A00_0000 | 32'(i);
    end
    rst     = 1'b1;
    read    = 1'b1;
    write   = 1'b0;
    address = 32'h0000_0010;
    data_wr = 32'h0;
    mask    = 4'h0;
    set_idle();
    exp_addr  = '0;
    exp_wdata = '0;
    exp_rd    = 32'h0;

    // Reset held for three edges with a read pending.
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step();
    step();
    chk("rst_data_rd_lit", data_rd, 32'h0);
    chk("rst_stall_lit", 32'(stall), 32'h0);
    rst  = 1'b0;
    read = 1'b0;
    step();

    do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    chk("chip_word4_lit", chip_mem[4], 32'hDEAD_BEEF);
    do_read(32'h0000_0010);
    chk("rd_deadbeef_lit", data_rd, 32'hDEAD_BEEF);

    do_write(32'h0000_0010, 32'h0000_AB00, 4'b0010, 1'b0);
    chk("chip_merge_lit", chip_mem[4], 32'hDEAD_ABEF);
    do_read(32'h0000_0010);
    chk("rd_merge_lit", data_rd, 32'hDEAD_ABEF);

    do_write(32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1'b1);
    chk("rw_both_write_lit", chip_mem[8], 32'hCAFE_F00D);
    do_write(32'h0000_0030, 32'h1111_2222, 4'h0, 1'b0);
    chk("mask0_untouched_lit", chip_mem[12], 32'h5A00_000C);
    chk("mask0_keeps_rd_lit", data_rd, 32'hDEAD_ABEF);

    do_read(32'h0000_0020);
    do_read(32'h0000_0020);
    chk("rd_repeat_lit", data_rd, 32'hCAFE_F00D);

    write_with_reset(32'h0000_0040, 32'h1234_5678);
    do_read(32'h0000_0020);
    do_read(32'h0030_0008);
    chk("rd_high_addr_lit", data_rd, 32'h5A00_0002);
    do_read(32'h0000_0010);
    do_read(32'h0000_0010);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
